// File: rtl/aes_pkg.sv
// Shared AES types, widths and S-box lookup tables.
// The forward S-box is only compiled in with INV_SUB_BYTES_FWD_EN.
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_WORD_W  = 32;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } fsm_e;

    // Byte 0x00 occupies the most significant byte of the table.
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[(255 - int'(b)) * 8 +: 8];
    endfunction

`ifdef INV_SUB_BYTES_FWD_EN
    localparam logic [2047:0] FWD_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] fwd_sbox(input logic [7:0] b);
        return FWD_SBOX[(255 - int'(b)) * 8 +: 8];
    endfunction
`endif

endpackage

// File: rtl/inv_sub_word.sv
// Bytewise inverse S-box on one 32-bit word.
// With INV_SUB_BYTES_FWD_EN, i_fwd selects the forward S-box instead.
module inv_sub_word
    import aes_pkg::*;
(
`ifdef INV_SUB_BYTES_FWD_EN
    input  logic                  i_fwd,
`endif
    input  logic [AES_WORD_W-1:0] i_word,
    output logic [AES_WORD_W-1:0] o_word
);

    always_comb begin
        o_word = '0;
        for (int b = 0; b < 4; b++) begin
`ifdef INV_SUB_BYTES_FWD_EN
            o_word[8*b +: 8] = i_fwd ? fwd_sbox(i_word[8*b +: 8])
                                     : inv_sbox(i_word[8*b +: 8]);
`else
            o_word[8*b +: 8] = inv_sbox(i_word[8*b +: 8]);
`endif
        end
    end

endmodule

// File: rtl/inv_sub_bytes_iter.sv
// Iterative inverse SubBytes, LANES words per cycle (1, 2 or 4).
// INV_SUB_BYTES_FWD_EN adds i_encrypt to select the forward S-box.
module inv_sub_bytes_iter
    import aes_pkg::*;
#(
    parameter int LANES = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
`ifdef INV_SUB_BYTES_FWD_EN
    input  logic                   i_encrypt,
`endif
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [AES_STATE_W-1:0] i_state,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [AES_STATE_W-1:0] o_state,
    output logic                   o_busy
);

    localparam int         GROUPS = 4 / LANES;
    localparam logic [1:0] LAST   = 2'(GROUPS - 1);

    generate
        if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
            $error("inv_sub_bytes_iter: LANES must be 1, 2 or 4");
        end
    endgenerate

    fsm_e                   state_q, state_d;
    logic [AES_STATE_W-1:0] work_q, work_d;
    logic [AES_STATE_W-1:0] res_q, res_d;
    logic [1:0]             cnt_q, cnt_d;
    logic                   ready_q, ready_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;
    logic                   mode_q, mode_d;

    logic [AES_WORD_W-1:0] lane_in  [LANES];
    logic [AES_WORD_W-1:0] lane_out [LANES];

    // Word w lives at bits [127-32w -: 32]; group cnt covers words cnt*LANES+l.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_in[l] = work_q[(3 - (int'(cnt_q) * LANES + l))
                                * AES_WORD_W +: AES_WORD_W];
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        inv_sub_word u_word (
`ifdef INV_SUB_BYTES_FWD_EN
            .i_fwd  (mode_q),
`endif
            .i_word (lane_in[l]),
            .o_word (lane_out[l])
        );
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        unique case (state_q)
            IDLE: begin
                if (i_valid && ready_q) begin
                    work_d  = i_state;
                    cnt_d   = '0;
`ifdef INV_SUB_BYTES_FWD_EN
                    mode_d  = i_encrypt;
`else
                    mode_d  = 1'b0;
`endif
                    state_d = BUSY;
                end
            end
            BUSY: begin
                for (int l = 0; l < LANES; l++) begin
                    res_d[(3 - (int'(cnt_q) * LANES + l))
                          * AES_WORD_W +: AES_WORD_W] = lane_out[l];
                end
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
        busy_d  = (state_d == BUSY);
        valid_d = (state_d == DONE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign o_ready = ready_q;
    assign o_valid = valid_q;
    assign o_busy  = busy_q;
    assign o_state = res_q;

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Bench for inv_sub_bytes_iter with LANES = 1, 2 and 4 instances.
// S-box reference is derived from GF(2^8) inversion plus the affine map.
module tb_inv_sub_bytes_iter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic         iv   [3];
    logic         ir   [3];
    logic [127:0] ist  [3];
`ifdef INV_SUB_BYTES_FWD_EN
    logic         ienc [3];
`endif
    logic         ov    [3];
    logic         ordy  [3];
    logic         obusy [3];
    logic [127:0] ost   [3];

    int total = 0;
    int bad   = 0;

    logic [127:0] sb [$];
    logic [7:0]   fwd_tab [256];
    logic [7:0]   inv_tab [256];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        inv_sub_bytes_iter #(.LANES(1 << g)) u_dut (
            .i_clk     (clk),
            .i_rst     (rst),
`ifdef INV_SUB_BYTES_FWD_EN
            .i_encrypt (ienc[g]),
`endif
            .i_valid   (iv[g]),
            .o_ready   (ordy[g]),
            .i_state   (ist[g]),
            .o_valid   (ov[g]),
            .i_ready   (ir[g]),
            .o_state   (ost[g]),
            .o_busy    (obusy[g])
        );
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        logic       hi;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            hi = x[7];
            x  = x << 1;
            if (hi) x = x ^ 8'h1b;
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_tables();
        logic [7:0] x, y, inv, s;
        for (int i = 0; i < 256; i++) begin
            x   = 8'(i);
            inv = 8'h00;
            for (int j = 1; j < 256; j++) begin
                y = 8'(j);
                if (gmul(x, y) == 8'h01) inv = y;
            end
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                ^ rotl8(inv, 4) ^ 8'h63;
            fwd_tab[i] = s;
            inv_tab[s] = x;
        end
    endtask

    function automatic logic [127:0] model_inv(input logic [127:0] s);
        logic [127:0] r = '0;
        for (int b = 0; b < 16; b++) r[8*b +: 8] = inv_tab[s[8*b +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rnd();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input int k, input logic [127:0] st, input logic enc);
        iv[k]  = 1'b1;
        ist[k] = st;
`ifdef INV_SUB_BYTES_FWD_EN
        ienc[k] = enc;
`else
        if (enc) $display("note: encrypt request ignored");
`endif
        tick();
        iv[k]  = 1'b0;
        ist[k] = rnd();
`ifdef INV_SUB_BYTES_FWD_EN
        ienc[k] = ~enc;
`endif
    endtask

    task automatic wait_valid(input int k, output int c, output logic rdy_seen);
        c = 0;
        rdy_seen = 1'b0;
        while (ov[k] !== 1'b1 && c < 50) begin
            if (ordy[k] !== 1'b0) rdy_seen = 1'b1;
            tick();
            c++;
        end
        if (ov[k] !== 1'b1) c = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            total++;
            if (ordy[k] !== 1'b1) begin
                bad++;
                $display("FAIL reset_ready k=%0d got=%b exp=1", k, ordy[k]);
            end
            total++;
            if (ov[k] !== 1'b0) begin
                bad++;
                $display("FAIL reset_valid k=%0d got=%b exp=0", k, ov[k]);
            end
            total++;
            if (obusy[k] !== 1'b0) begin
                bad++;
                $display("FAIL reset_busy k=%0d got=%b exp=0", k, obusy[k]);
            end
            total++;
            if (ost[k] !== 128'h0) begin
                bad++;
                $display("FAIL reset_state k=%0d got=%h exp=0", k, ost[k]);
            end
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_vectors();
        logic [127:0] pin [4];
        logic [127:0] pexp [4];
        logic [127:0] e;
        int           c;
        logic         rs;
        pin[0]  = 128'h637c777bf26b6fc53001672bfed7ab76;
        pexp[0] = 128'h000102030405060708090a0b0c0d0e0f;
        pin[1]  = {16{8'h00}};
        pexp[1] = {16{8'h52}};
        pin[2]  = {16{8'h16}};
        pexp[2] = {16{8'hff}};
        pin[3]  = {16{8'hed}};
        pexp[3] = {16{8'h53}};
        for (int k = 0; k < 3; k++) begin
            for (int p = 0; p < 4; p++) begin
                ir[k] = 1'b1;
                total++;
                if (ordy[k] !== 1'b1) begin
                    bad++;
                    $display("FAIL idle_ready k=%0d got=%b exp=1", k, ordy[k]);
                end
                accept(k, pin[p], 1'b0);
                sb.push_back(pexp[p]);
                total++;
                if (ordy[k] !== 1'b0 || obusy[k] !== 1'b1) begin
                    bad++;
                    $display("FAIL busy_flags k=%0d got=%b%b exp=01",
                             k, ordy[k], obusy[k]);
                end
                wait_valid(k, c, rs);
                total++;
                if (c !== (4 >> k)) begin
                    bad++;
                    $display("FAIL latency k=%0d p=%0d got=%0d exp=%0d",
                             k, p, c, 4 >> k);
                end
                total++;
                if (rs !== 1'b0 || ordy[k] !== 1'b0) begin
                    bad++;
                    $display("FAIL ready_early k=%0d got=%b exp=0", k, rs | ordy[k]);
                end
                e = sb.pop_front();
                total++;
                if (ost[k] !== e) begin
                    bad++;
                    $display("FAIL vector k=%0d p=%0d got=%h exp=%h", k, p, ost[k], e);
                end
                tick();
                total++;
                if (ov[k] !== 1'b0 || ordy[k] !== 1'b1) begin
                    bad++;
                    $display("FAIL post_hs k=%0d got=%b%b exp=01", k, ov[k], ordy[k]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] a, b, e;
        int           c;
        logic         rs;
        ir[0] = 1'b0;
        a = rnd();
        accept(0, a, 1'b0);
        sb.push_back(model_inv(a));
        wait_valid(0, c, rs);
        total++;
        if (c !== 4) begin
            bad++;
            $display("FAIL bp_latency got=%0d exp=4", c);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (ov[0] !== 1'b1 || ost[0] !== sb[0]) begin
                bad++;
                $display("FAIL bp_hold i=%0d got=%b/%h exp=1/%h", i, ov[0], ost[0], sb[0]);
            end
        end
        b = rnd();
        ir[0]  = 1'b1;
        iv[0]  = 1'b1;
        ist[0] = b;
        tick();
        e = sb.pop_front();
        total++;
        if (ov[0] !== 1'b0 || ordy[0] !== 1'b1 || obusy[0] !== 1'b0) begin
            bad++;
            $display("FAIL bp_no_accept got=%b%b%b exp=010", ov[0], ordy[0], obusy[0]);
        end
        tick();
        iv[0]  = 1'b0;
        ist[0] = rnd();
        sb.push_back(model_inv(b));
        wait_valid(0, c, rs);
        e = sb.pop_front();
        total++;
        if (c !== 4 || ost[0] !== e) begin
            bad++;
            $display("FAIL bp_second got=%0d/%h exp=4/%h", c, ost[0], e);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [127:0] a, e;
        int           c;
        logic         rs;
        ir[0] = 1'b1;
        a = rnd();
        accept(0, a, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (ov[0] !== 1'b0 || ordy[0] !== 1'b1 || obusy[0] !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_flags got=%b%b%b exp=010", ov[0], ordy[0], obusy[0]);
        end
        total++;
        if (ost[0] !== 128'h0) begin
            bad++;
            $display("FAIL rst_mid_state got=%h exp=0", ost[0]);
        end
        a = rnd();
        accept(0, a, 1'b0);
        sb.push_back(model_inv(a));
        wait_valid(0, c, rs);
        e = sb.pop_front();
        total++;
        if (c !== 4 || ost[0] !== e) begin
            bad++;
            $display("FAIL rst_mid_after got=%0d/%h exp=4/%h", c, ost[0], e);
        end
        tick();
    endtask

    task automatic test_back_to_back(input int k);
        int           sent = 0;
        int           got = 0;
        logic         acc, hs;
        logic [127:0] e;
        sb.delete();
        ir[k]  = 1'b1;
        iv[k]  = 1'b1;
        ist[k] = rnd();
        for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
            acc = ordy[k] && iv[k];
            hs  = ov[k] && ir[k];
            if (hs) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL b2b_extra k=%0d got=%h exp=none", k, ost[k]);
                end else begin
                    e = sb.pop_front();
                    if (ost[k] !== e) begin
                        bad++;
                        $display("FAIL b2b_data k=%0d n=%0d got=%h exp=%h",
                                 k, got, ost[k], e);
                    end
                end
                got++;
            end
            if (acc) begin
                sb.push_back(model_inv(ist[k]));
                sent++;
            end
            tick();
            if (acc) begin
                if (sent < 8) ist[k] = rnd();
                else iv[k] = 1'b0;
            end
        end
        iv[k] = 1'b0;
        total++;
        if (got !== 8 || sent !== 8 || sb.size() !== 0) begin
            bad++;
            $display("FAIL b2b_count k=%0d got=%0d/%0d/%0d exp=8/8/0",
                     k, got, sent, sb.size());
        end
    endtask

`ifdef INV_SUB_BYTES_FWD_EN
    task automatic test_fwd();
        logic [127:0] e;
        int           c;
        logic         rs;
        ir[0] = 1'b1;
        accept(0, 128'h000102030405060708090a0b0c0d0e0f, 1'b1);
        sb.push_back(128'h637c777bf26b6fc53001672bfed7ab76);
        wait_valid(0, c, rs);
        e = sb.pop_front();
        total++;
        if (c !== 4 || ost[0] !== e) begin
            bad++;
            $display("FAIL fwd_enc got=%0d/%h exp=4/%h", c, ost[0], e);
        end
        tick();
        accept(0, 128'h637c777bf26b6fc53001672bfed7ab76, 1'b0);
        sb.push_back(128'h000102030405060708090a0b0c0d0e0f);
        wait_valid(0, c, rs);
        e = sb.pop_front();
        total++;
        if (c !== 4 || ost[0] !== e) begin
            bad++;
            $display("FAIL fwd_dec got=%0d/%h exp=4/%h", c, ost[0], e);
        end
        tick();
    endtask
`endif

    initial begin
        for (int k = 0; k < 3; k++) begin
            iv[k]  = 1'b0;
            ir[k]  = 1'b0;
            ist[k] = '0;
`ifdef INV_SUB_BYTES_FWD_EN
            ienc[k] = 1'b0;
`endif
        end
        build_tables();
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_mid();
        test_back_to_back(0);
        test_back_to_back(1);
        test_back_to_back(2);
`ifdef INV_SUB_BYTES_FWD_EN
        test_fwd();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
